// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - pin synchroniser, per-bit debouncer and sticky edge-event flags
module gpio_in_conditioner #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] in_stable,
    output logic [WIDTH-1:0] evt_status,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] evt_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per bit; nothing may sit between stages.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Count consecutive cycles the synchronised bit disagrees with in_stable; accept on the last one.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // An accepted bit flips in_stable, so its new value tells the edge direction.
    assign rise = accept & sync_s & rise_en;
    assign fall = accept & ~sync_s & fall_en;

    // Debounce counters, accepted value and sticky flags; a new edge wins over a same-cycle clear.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            evt_q    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_q ^ accept;
            evt_q    <= (evt_q & ~evt_clr) | rise | fall;
        end
    end

    assign in_stable  = stable_q;
    assign evt_status = evt_q;
    assign irq        = |evt_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - randomized and directed self-checking bench for gpio_in_conditioner
module tb_gpio_in_conditioner;

    localparam int W = 32;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pin_in;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] evt_clr;
    logic [W-1:0] in_stable;
    logic [W-1:0] evt_status;
    logic         irq;

    gpio_in_conditioner #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .pin_in(pin_in),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .evt_clr(evt_clr),
        .in_stable(in_stable),
        .evt_status(evt_status),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: pins seen at past edges, per-bit run length of disagreement, accepted value, flags.
    logic [W-1:0] hist [S];
    int           run  [W];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_evt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < S; k++) hist[k] = '0;
        for (int i = 0; i < W; i++) run[i] = 0;
        m_stable = '0;
        m_evt    = '0;
    endtask

    // A bit is accepted once the synchronised pin (the pin value S edges back) has disagreed
    // with the accepted value on D consecutive edges.
    task automatic model_edge();
        logic [W-1:0] s;
        logic [W-1:0] acc;
        if (!rst_n) begin
            model_clear();
            return;
        end
        s   = hist[S-1];
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_stable[i]) begin
                run[i] = run[i] + 1;
                if (run[i] == D) begin
                    acc[i] = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        m_evt    = (m_evt & ~evt_clr) | (acc & s & rise_en) | (acc & ~s & fall_en);
        m_stable = m_stable ^ acc;
        for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pin_in;
    endtask

    // One clock: model follows the edge, outputs compared half a cycle later.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("in_stable", in_stable, m_stable);
        chk("evt_status", evt_status, m_evt);
        chk("irq", {31'b0, irq}, {31'b0, |m_evt});
    endtask

    int hi_cnt;

    initial begin
        rst_n   = 1'b0;
        pin_in  = 32'h0000CE00;
        rise_en = '0;
        fall_en = '0;
        evt_clr = '0;
        model_clear();
        step();
        step();
        chk("reset_in_stable", in_stable, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Pins already high at reset release.
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("release_latency", in_stable, (k < 6) ? 32'h0 : 32'h0000CE00);
            chk("release_evt", evt_status, 32'h0);
        end

        // Glitch filtering on bit0.
        pin_in = '0;
        repeat (8) step();
        pin_in[0] = 1'b1;
        repeat (3) step();
        pin_in[0] = 1'b0;
        repeat (10) step();
        chk("glitch3_stable", in_stable, 32'h0);
        chk("glitch3_evt", evt_status, 32'h0);
        pin_in[0] = 1'b1;
        repeat (4) step();
        pin_in[0] = 1'b0;
        hi_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (in_stable[0]) hi_cnt++;
        end
        chk("pulse4_high_cycles", hi_cnt, 4);

        // Qualified rise on bit3, then unqualified fall.
        rise_en = 32'h8;
        pin_in  = 32'h8;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("rise_before", evt_status | in_stable, 32'h0);
            if (k == 6) begin
                chk("rise_stable", in_stable, 32'h8);
                chk("rise_evt", evt_status, 32'h8);
                chk("rise_irq", {31'b0, irq}, 32'h1);
            end
        end
        pin_in = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("fall_stable", in_stable, (k < 6) ? 32'h8 : 32'h0);
        end
        chk("fall_evt_kept", evt_status, 32'h8);

        // Write-1-to-clear.
        evt_clr = 32'h8;
        step();
        evt_clr = '0;
        chk("clr_evt", evt_status, 32'h0);
        chk("clr_irq", {31'b0, irq}, 32'h0);

        // Set wins over a coincident clear.
        pin_in = 32'h8;
        repeat (6) step();
        pin_in = '0;
        repeat (6) step();
        pin_in = 32'h8;
        repeat (5) step();
        evt_clr = 32'h8;
        step();
        evt_clr = '0;
        chk("collide_evt", evt_status, 32'h8);
        chk("collide_irq", {31'b0, irq}, 32'h1);

        // Async reset in the middle of a bit5 debounce.
        pin_in = 32'h20;
        repeat (4) step();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_stable", in_stable, 32'h0);
        chk("async_rst_evt", evt_status, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("rst_stale_bit5", in_stable, 32'h0);
            if (k == 6) chk("rst_accept_bit5", in_stable, 32'h20);
        end

        // Randomized traffic with sparse pin changes, enable reshuffles, clears and rare resets.
        for (int n = 0; n < 4000; n++) begin
            if (n % 64 == 0) begin
                rise_en = $urandom();
                fall_en = $urandom();
            end
            if ($urandom_range(0, 2) == 0) pin_in = pin_in ^ ($urandom() & $urandom());
            evt_clr = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom() & $urandom()) : '0;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                model_clear();
                #1;
                chk("rand_async_rst", in_stable | evt_status, 32'h0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
